regfile_write_seq: RTL and testbench
====================================

# regfile_write_seq

Write sequencer directly upstream of the register bank. It accepts write requests over a valid/ready handshake and buffers them in a small FIFO. It retires one write per cycle by driving a one-hot clock-enable vector and a shared data bus into the bank's `register` instances. It also provides a forwarding lookup so readers can see writes that are accepted but not yet committed.

## Interface
Parameters:
- `SIZE`, 4: data width; matches the bank register width.
- `NREGS`, 8: number of registers in the bank.
- `AW`, 3: address width; `2**AW >= NREGS`.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.

Ports:
- `clk` in, 1: clock; all state updates on posedge.
- `clr` in, 1: reset, asynchronous, active-low.
- `wr_valid` in, 1: write request present.
- `wr_addr` in, AW: target register index.
- `wr_data` in, SIZE: write data.
- `wr_ready` out, 1: request accepted at the edge where `wr_valid & wr_ready`.
- `hold` in, 1: bank stall; no retirement while high.
- `reg_en` out, NREGS: one-hot per-register clock enable; drives each register's `clock_enable`.
- `reg_d` out, SIZE: broadcast write data; drives every register's `d`.
- `rd_addr` in, AW: forwarding lookup address.
- `fwd_hit` out, 1: a pending write to `rd_addr` exists.
- `fwd_data` out, SIZE: data of the youngest pending write to `rd_addr`.
- `err_oor` out, 1: sticky flag; an accepted request had `wr_addr >= NREGS`.
- `level` out, log2(DEPTH)+1: current FIFO occupancy.

## Operation
- Reset (`clr` low, asynchronous) sets all outputs and state to zero:
  - `reg_en`=0, `reg_d`=0, FIFO empty, `level`=0, `err_oor`=0, `wr_ready`=1 once `clr` deasserts.
  - The bank registers share `clr`, so a reset mid-operation discards all pending writes consistently.
- Push:
  - `wr_ready = (level != DEPTH)`, taken from registered occupancy.
  - No same-cycle pass-through when full.
- Out-of-range requests (`wr_addr >= NREGS`):
  - Accepted (handshake completes) but never stored.
  - Set `err_oor`, which stays set until reset.
- Retire (output stage), evaluated each posedge:
  - If FIFO is non-empty and `hold`=0: pop the head, `reg_en <= 1 << head.addr`, `reg_d <= head.data`.
  - Otherwise: `reg_en <= 0`; `reg_d` holds its previous value.
- Simultaneous push and pop are both allowed in the same edge; `level` is unchanged.
- Push into an empty FIFO: the entry becomes eligible for pop at the next edge, never the same edge.
- Pointers wrap modulo DEPTH; `level` distinguishes full from empty.
- Forwarding (combinational):
  - Search the output stage (valid when `reg_en != 0`), then the FIFO from head to tail.
  - The youngest match wins, i.e. the tail-most FIFO match, else the output stage.
  - `fwd_data` = 0 when `fwd_hit` = 0.
- Multiple writes to the same address commit in acceptance order.

## Timing
- An accepted write at edge N:
  - Enters the FIFO at N.
  - Earliest `reg_en`/`reg_d` assertion is after edge N+1.
  - The bank register captures at edge N+2.
- Total latency is 2 cycles plus 1 cycle per queued entry ahead of it plus 1 cycle per cycle of `hold`.
- Throughput: one write per cycle sustained.
- `reg_en` is high for exactly one cycle per retired write.
- `hold` is sampled at the edge:
  - `hold` high at edge E means `reg_en`=0 for the cycle after E.
  - The head entry is retained.
- `fwd_hit`/`fwd_data` reflect state after the most recent edge. There is no combinational path from `wr_*` to `fwd_*`.
- `wr_ready` depends only on registered state.

## Structure
- Shared package `regfile_pkg`:
  - Default constants `SIZE`, `NREGS`, `AW`, `DEPTH`.
  - A write-entry record type `{addr, data}` reused by the bank's read mux.
- Sub-module `wr_fifo`:
  - Synchronous FIFO with push/pop/level.
  - Exposes all entries plus head/tail pointers for the forwarding search.
- Top level holds the output stage, decode, forwarding priority logic and `err_oor`.

## Test plan
- Single write: push addr 3, data 0xA on an idle block. `reg_en`=0b00001000 and `reg_d`=0xA one cycle after the following edge, for exactly one cycle. Register 3 reads 0xA at N+2.
- Fill/backpressure: push 5 back-to-back with `hold`=1. Four accepted, `level`=4, `wr_ready`=0. Releasing `hold` retires them in order at one per cycle, and `wr_ready` returns after the first pop.
- Forwarding: push (2,0x5) then (2,0x9) with `hold`=1 and `rd_addr`=2. `fwd_hit`=1, `fwd_data`=0x9. With `rd_addr`=4, `fwd_hit`=0.
- Out-of-range: with NREGS=6, push addr 7. Handshake completes, `err_oor`=1, no `reg_en` pulse, `level` stays 0.
- Simultaneous push/pop at `level`=2 with `hold`=0. `level` stays 2 and order is preserved.
- Reset mid-operation: drop `clr` with 3 entries pending. `reg_en`, `reg_d` and `level` go to 0 immediately, with no commits after `clr` returns.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and write-entry record for the register bank and its write sequencer.
package regfile_pkg;

  localparam int DEF_SIZE  = 4;
  localparam int DEF_NREGS = 8;
  localparam int DEF_AW    = 3;
  localparam int DEF_DEPTH = 4;

  typedef struct packed {
    logic [DEF_AW-1:0]   addr;
    logic [DEF_SIZE-1:0] data;
  } wr_entry_t;

  function automatic wr_entry_t make_entry(input logic [DEF_AW-1:0] a,
                                           input logic [DEF_SIZE-1:0] d);
    wr_entry_t e;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

endpackage

// File: rtl/regfile_write_seq_fifo.sv
// Small synchronous FIFO; all slots and both pointers are visible so the
// top level can search pending writes for forwarding.
module wr_fifo
  import regfile_pkg::*;
#(
  parameter  int W     = DEF_AW + DEF_SIZE,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              din,
  output logic [DEPTH-1:0][W-1:0]   entries,
  output logic [PW-1:0]             head,
  output logic [PW-1:0]             tail,
  output logic [PW:0]               level
);

  // Pointers wrap naturally at DEPTH; level tells full from empty.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      entries <= '0;
      head    <= '0;
      tail    <= '0;
      level   <= '0;
    end else begin
      if (push) begin
        entries[tail] <= din;
        tail          <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (PW+1)'(1);
        2'b01:   level <= level - (PW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_seq.sv
// Write sequencer in front of the register bank: buffers accepted writes,
// retires one per cycle as a one-hot enable plus shared data, and forwards pending data.
module regfile_write_seq
  import regfile_pkg::*;
#(
  parameter  int SIZE  = DEF_SIZE,
  parameter  int NREGS = DEF_NREGS,
  parameter  int AW    = DEF_AW,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_valid,
  input  logic [AW-1:0]    wr_addr,
  input  logic [SIZE-1:0]  wr_data,
  output logic             wr_ready,
  input  logic             hold,
  output logic [NREGS-1:0] reg_en,
  output logic [SIZE-1:0]  reg_d,
  input  logic [AW-1:0]    rd_addr,
  output logic             fwd_hit,
  output logic [SIZE-1:0]  fwd_data,
  output logic             err_oor,
  output logic [PW:0]      level
);

  localparam int            W       = AW + SIZE;
  localparam logic [AW:0]   NREGS_L = (AW+1)'(NREGS);
  localparam logic [PW:0]   FULL_L  = (PW+1)'(DEPTH);

  logic                     accept;
  logic                     in_range;
  logic                     push;
  logic                     pop;
  logic [DEPTH-1:0][W-1:0]  entries;
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [W-1:0]             head_entry;
  logic [AW-1:0]            out_addr;
  logic                     fifo_hit;
  logic [SIZE-1:0]          fifo_data;
  logic [PW-1:0]            idx;

  assign wr_ready   = (level != FULL_L);
  assign accept     = wr_valid & wr_ready;
  assign in_range   = ({1'b0, wr_addr} < NREGS_L);
  assign push       = accept & in_range;
  // Registered level keeps a freshly pushed entry from popping on the same edge.
  assign pop        = (level != '0) & ~hold;
  assign head_entry = entries[head];

  wr_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .push    (push),
    .pop     (pop),
    .din     ({wr_addr, wr_data}),
    .entries (entries),
    .head    (head),
    .tail    (tail),
    .level   (level)
  );

  // Output stage: reg_d keeps its last value between retirements.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      reg_en   <= '0;
      reg_d    <= '0;
      out_addr <= '0;
      err_oor  <= 1'b0;
    end else begin
      err_oor <= err_oor | (accept & ~in_range);
      if (pop) begin
        reg_en   <= NREGS'(1) << head_entry[W-1:SIZE];
        reg_d    <= head_entry[SIZE-1:0];
        out_addr <= head_entry[W-1:SIZE];
      end else begin
        reg_en <= '0;
      end
    end
  end

  // Walk back from the tail so the first match is the youngest pending write.
  always_comb begin
    fifo_hit  = 1'b0;
    fifo_data = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = tail - PW'(k + 1);
      if (!fifo_hit && ((PW+1)'(k) < level) && (entries[idx][W-1:SIZE] == rd_addr)) begin
        fifo_hit  = 1'b1;
        fifo_data = entries[idx][SIZE-1:0];
      end
    end
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fifo_hit) begin
      fwd_hit  = 1'b1;
      fwd_data = fifo_data;
    end else if ((reg_en != '0) && (out_addr == rd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = reg_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_seq.sv
// Directed bench for regfile_write_seq (6-register bank, 4-deep FIFO): vector table
// plus hand-written fill, reset and out-of-range sequences.
module tb_regfile_write_seq;
  import regfile_pkg::*;

  logic       clk;
  logic       clr;
  logic       wr_valid;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_ready;
  logic       hold;
  logic [5:0] reg_en;
  logic [3:0] reg_d;
  logic [2:0] rd_addr;
  logic       fwd_hit;
  logic [3:0] fwd_data;
  logic       err_oor;
  logic [2:0] level;

  int vectors;
  int miscompares;

  typedef struct {
    logic       v;
    logic [2:0] a;
    logic [3:0] d;
    logic       h;
    logic [2:0] r;
    logic       rdy;
    logic [5:0] en;
    logic [3:0] q;
    logic       hit;
    logic [3:0] fd;
    logic       err;
    logic [2:0] lvl;
  } vec_t;

  vec_t tbl [15];

  regfile_write_seq #(
    .SIZE  (4),
    .NREGS (6),
    .AW    (3),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .hold     (hold),
    .reg_en   (reg_en),
    .reg_d    (reg_d),
    .rd_addr  (rd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .err_oor  (err_oor),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [2:0] a, input logic [3:0] d,
                               input logic h, input logic [2:0] r);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    hold     = h;
    rd_addr  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string name, input string field,
                            input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s %s: got %0h, expected %0h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic rdy, input logic [5:0] en,
                             input logic [3:0] q, input logic hit, input logic [3:0] fd,
                             input logic err, input logic [2:0] lvl);
    vectors++;
    checkField(name, "wr_ready", 8'(wr_ready), 8'(rdy));
    checkField(name, "reg_en",   8'(reg_en),   8'(en));
    checkField(name, "reg_d",    8'(reg_d),    8'(q));
    checkField(name, "fwd_hit",  8'(fwd_hit),  8'(hit));
    checkField(name, "fwd_data", 8'(fwd_data), 8'(fd));
    checkField(name, "err_oor",  8'(err_oor),  8'(err));
    checkField(name, "level",    8'(level),    8'(lvl));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clr         = 1'b0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    hold        = 1'b0;
    rd_addr     = '0;

    //          v     a     d      h     r   | rdy   en     q      hit   fd     err   lvl
    tbl[0]  = '{1'b1, 3'd3, 4'hA, 1'b0, 3'd3, 1'b1, 6'h00, 4'h0, 1'b1, 4'hA, 1'b0, 3'd1};
    tbl[1]  = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd3, 1'b1, 6'h08, 4'hA, 1'b1, 4'hA, 1'b0, 3'd0};
    tbl[2]  = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd3, 1'b1, 6'h00, 4'hA, 1'b0, 4'h0, 1'b0, 3'd0};
    tbl[3]  = '{1'b1, 3'd2, 4'h5, 1'b1, 3'd2, 1'b1, 6'h00, 4'hA, 1'b1, 4'h5, 1'b0, 3'd1};
    tbl[4]  = '{1'b1, 3'd2, 4'h9, 1'b1, 3'd2, 1'b1, 6'h00, 4'hA, 1'b1, 4'h9, 1'b0, 3'd2};
    tbl[5]  = '{1'b0, 3'd0, 4'h0, 1'b1, 3'd4, 1'b1, 6'h00, 4'hA, 1'b0, 4'h0, 1'b0, 3'd2};
    tbl[6]  = '{1'b1, 3'd1, 4'h3, 1'b0, 3'd2, 1'b1, 6'h04, 4'h5, 1'b1, 4'h9, 1'b0, 3'd2};
    tbl[7]  = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd2, 1'b1, 6'h04, 4'h9, 1'b1, 4'h9, 1'b0, 3'd1};
    tbl[8]  = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd1, 1'b1, 6'h02, 4'h3, 1'b1, 4'h3, 1'b0, 3'd0};
    tbl[9]  = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd1, 1'b1, 6'h00, 4'h3, 1'b0, 4'h0, 1'b0, 3'd0};
    tbl[10] = '{1'b1, 3'd7, 4'hF, 1'b0, 3'd7, 1'b1, 6'h00, 4'h3, 1'b0, 4'h0, 1'b1, 3'd0};
    tbl[11] = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd7, 1'b1, 6'h00, 4'h3, 1'b0, 4'h0, 1'b1, 3'd0};
    tbl[12] = '{1'b1, 3'd5, 4'hE, 1'b0, 3'd5, 1'b1, 6'h00, 4'h3, 1'b1, 4'hE, 1'b1, 3'd1};
    tbl[13] = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd5, 1'b1, 6'h20, 4'hE, 1'b1, 4'hE, 1'b1, 3'd0};
    tbl[14] = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd5, 1'b1, 6'h00, 4'hE, 1'b0, 4'h0, 1'b1, 3'd0};

    #12;
    checkOutput("reset", 1'b1, 6'h00, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0);
    clr = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].h, tbl[i].r);
      checkOutput($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].en, tbl[i].q,
                  tbl[i].hit, tbl[i].fd, tbl[i].err, tbl[i].lvl);
    end

    // Fill under hold: the fifth request must be refused.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 3'(i), 4'(i + 1), 1'b1, 3'd0);
    end
    checkOutput("fill", 1'b0, 6'h00, 4'hE, 1'b1, 4'h1, 1'b1, 3'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 3'(i));
      checkOutput($sformatf("drain%0d", i), 1'b1, 6'(1 << i), 4'(i + 1),
                  1'b1, 4'(i + 1), 1'b1, 3'(3 - i));
    end
    applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 3'd4);
    checkOutput("drain_idle", 1'b1, 6'h00, 4'h4, 1'b0, 4'h0, 1'b1, 3'd0);

    // Reset with entries pending and a retirement on the bus.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 3'(i + 1), 4'(i + 6), 1'b1, 3'd2);
    end
    applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 3'd2);
    checkOutput("pre_reset", 1'b1, 6'h02, 4'h6, 1'b1, 4'h7, 1'b1, 3'd3);
    clr = 1'b0;
    #2;
    checkOutput("async_reset", 1'b1, 6'h00, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 3'd2);
      checkOutput($sformatf("post_reset%0d", i), 1'b1, 6'h00, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0);
    end

    // First out-of-range address (NREGS) on a clean flag.
    applyStimulus(1'b1, 3'd6, 4'h3, 1'b0, 3'd6);
    checkOutput("oor6", 1'b1, 6'h00, 4'h0, 1'b0, 4'h0, 1'b1, 3'd0);
    applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 3'd6);
    checkOutput("oor6_idle", 1'b1, 6'h00, 4'h0, 1'b0, 4'h0, 1'b1, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
